// File: rtl/audio_pwm_periph.sv
// Memory-mapped audio output: CPU stores feed a PCM sample FIFO, a programmable
// sample-rate timer pops one sample per tick into the duty register of a free-running PWM.
module audio_pwm_periph #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          SAMPLE_W    = 8,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          IRQ_THRESH  = 4,
  parameter logic [31:0] DEFAULT_DIV = 32'd2267
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  output logic [31:0] bus_rdata,
  output logic        pwm_out,
  output logic        irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]    LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]    LVL_IRQ  = LVL_W'(IRQ_THRESH);
  localparam logic [SAMPLE_W-1:0] PWM_LAST = SAMPLE_W'((2 ** SAMPLE_W) - 2);

  logic                r_en;
  logic [31:0]         r_div;
  logic [31:0]         r_div_cnt;
  logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_ovf;
  logic                r_unf;
  logic [SAMPLE_W-1:0] r_duty;
  logic [SAMPLE_W-1:0] r_pwm_cnt;
  logic                r_pwm_out;
  logic                r_irq;

  logic                w_sel;
  logic [1:0]          w_off;
  logic                w_wr_ctrl, w_wr_stat, w_wr_data, w_wr_div;
  logic                w_flush, w_empty, w_full, w_tick;
  logic                w_pop, w_push, w_ovf_set, w_unf_set;
  logic [LVL_W-1:0]    w_level_next;
  logic                w_unused;

  // Single-cycle bus with no handshake: a selected store commits on the next rising
  // edge, and read data is a pure function of the current address and register state.
  assign w_sel     = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off     = bus_addr[3:2];
  assign w_unused  = ^bus_addr[1:0];
  assign w_wr_ctrl = w_sel & bus_we & (w_off == 2'd0);
  assign w_wr_stat = w_sel & bus_we & (w_off == 2'd1);
  assign w_wr_data = w_sel & bus_we & (w_off == 2'd2);
  assign w_wr_div  = w_sel & bus_we & (w_off == 2'd3);

  assign w_flush   = w_wr_ctrl & bus_wdata[1];
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LVL_FULL);
  assign w_tick    = r_en & (r_div_cnt == r_div);

  // Flush overrides both FIFO ports; a pop frees the slot a same-cycle push needs.
  assign w_pop     = w_tick & ~w_empty & ~w_flush;
  assign w_push    = w_wr_data & ~w_flush & (~w_full | w_pop);
  assign w_ovf_set = w_wr_data & ~w_flush & w_full & ~w_pop;
  assign w_unf_set = w_tick & w_empty;

  always_comb begin
    w_level_next = r_level;
    if (w_flush)
      w_level_next = '0;
    else if (w_push && !w_pop)
      w_level_next = r_level + 1'b1;
    else if (w_pop && !w_push)
      w_level_next = r_level - 1'b1;
  end

  always_comb begin
    bus_rdata = '0;
    if (w_sel) begin
      case (w_off)
        2'd0:    bus_rdata = {31'd0, r_en};
        2'd1:    bus_rdata = {16'd0, 8'(r_level), 4'd0, r_unf, r_ovf, w_full, w_empty};
        2'd3:    bus_rdata = r_div;
        default: bus_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= bus_wdata[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en      <= 1'b0;
      r_div     <= DEFAULT_DIV;
      r_div_cnt <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_duty    <= '0;
      r_pwm_cnt <= '0;
      r_pwm_out <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_en  <= bus_wdata[0];
      if (w_wr_div)  r_div <= bus_wdata;

      // A counter left above a freshly lowered DIV runs on through the 2**32 wrap.
      if (!r_en || w_tick) r_div_cnt <= '0;
      else                 r_div_cnt <= r_div_cnt + 32'd1;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_flush)    r_rd_ptr <= r_wr_ptr;
      else if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_next;

      if (w_pop) r_duty <= r_mem[r_rd_ptr];

      r_ovf <= w_ovf_set | (r_ovf & ~(w_wr_stat & bus_wdata[2]));
      r_unf <= w_unf_set | (r_unf & ~(w_wr_stat & bus_wdata[3]));

      if (!r_en || r_pwm_cnt == PWM_LAST) r_pwm_cnt <= '0;
      else                                r_pwm_cnt <= r_pwm_cnt + 1'b1;

      r_pwm_out <= r_en & (r_pwm_cnt < r_duty);
      r_irq     <= r_en & (w_level_next <= LVL_IRQ);
    end
  end

  assign pwm_out = r_pwm_out;
  assign irq     = r_irq;
endmodule

// File: tb/tb_audio_pwm_periph.sv
// Bench for audio_pwm_periph: vector table, directed multi-cycle corner sequences and
// randomized bus traffic, all compared each cycle against a queue-based behavioural model.
module tb_audio_pwm_periph;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_DATA = BASE + 32'h8;
  localparam logic [31:0] A_DIV  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_rdata;
  logic        pwm_out;
  logic        irq;

  always #5 clk = ~clk;

  audio_pwm_periph dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .pwm_out   (pwm_out),
    .irq       (irq)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: the sample FIFO is a plain queue, timers are counters.
  logic [7:0]  exp_q[$];
  logic        m_en, m_ovf, m_unf, m_pwm, m_irq;
  logic [31:0] m_div, m_div_cnt;
  int          m_phase;
  logic [7:0]  m_duty;
  logic [31:0] last_rdata;
  logic        last_pwm, last_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {31'd0, m_en};
      2'd1:    return {16'd0, 8'(exp_q.size()), 4'd0, m_unf, m_ovf,
                       exp_q.size() == 16, exp_q.size() == 0};
      2'd3:    return m_div;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_en = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_pwm = 1'b0; m_irq = 1'b0;
    m_div = 32'd2267; m_div_cnt = '0; m_phase = 0; m_duty = '0;
  endtask

  task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic we);
    logic sel, wc, ws, wd, wv, flush, tick, pop, push, ovf_set, unf_set;
    int n;
    sel = (a[31:4] == BASE[31:4]);
    wc = sel && we && a[3:2] == 2'd0;
    ws = sel && we && a[3:2] == 2'd1;
    wd = sel && we && a[3:2] == 2'd2;
    wv = sel && we && a[3:2] == 2'd3;
    flush = wc && d[1];
    tick = m_en && (m_div_cnt == m_div);
    n = exp_q.size();
    pop = tick && n > 0 && !flush;
    unf_set = tick && n == 0;
    push = wd && !flush && (n < 16 || pop);
    ovf_set = wd && !flush && n == 16 && !pop;
    m_pwm = m_en && (m_phase < int'(m_duty));
    if (pop) m_duty = exp_q.pop_front();
    if (push) exp_q.push_back(d[7:0]);
    if (flush) exp_q.delete();
    m_irq = m_en && exp_q.size() <= 4;
    m_ovf = ovf_set || (m_ovf && !(ws && d[2]));
    m_unf = unf_set || (m_unf && !(ws && d[3]));
    m_div_cnt = (!m_en || tick) ? 32'd0 : m_div_cnt + 32'd1;
    m_phase = m_en ? (m_phase + 1) % 255 : 0;
    if (wv) m_div = d;
    if (wc) m_en = d[0];
  endtask

  // One bus cycle: drive mid-low-phase, compare outputs, then advance the model.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_we = we;
    #1;
    last_rdata = bus_rdata; last_pwm = pwm_out; last_irq = irq;
    chk("rdata", bus_rdata, m_read(a));
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("irq", 32'(irq), 32'(m_irq));
    @(posedge clk);
    model_step(a, d, we);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus_we = 1'b0; bus_addr = A_STAT;
    model_reset();
    #1;
    chk("rst_pwm_out", 32'(pwm_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_stat", bus_rdata, 32'h0000_0001);
    bus_addr = A_DIV; #1;
    chk("rst_div", bus_rdata, 32'd2267);
    bus_addr = A_CTRL; #1;
    chk("rst_ctrl", bus_rdata, 32'd0);
    bus_addr = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    model_step('0, '0, 1'b0);
  endtask

  task automatic count_high(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      cyc('0, '0, 1'b0);
      cnt += int'(last_pwm);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int hi;
    int r;
    logic [31:0] nd;

    tbl[0]  = '{A_STAT, 32'h0, 1'b0, 32'h0000_0001};
    tbl[1]  = '{A_DIV, 32'h0, 1'b0, 32'd2267};
    tbl[2]  = '{A_DATA, 32'h11, 1'b1, 32'h0};
    tbl[3]  = '{A_DATA, 32'h122, 1'b1, 32'h0};
    tbl[4]  = '{A_DATA, 32'h33, 1'b1, 32'h0};
    tbl[5]  = '{A_STAT, 32'h0, 1'b0, 32'h0000_0300};
    tbl[6]  = '{BASE + 32'h5, 32'h0, 1'b0, 32'h0000_0300};
    tbl[7]  = '{32'h2000_0008, 32'h44, 1'b1, 32'h0};
    tbl[8]  = '{A_STAT, 32'h0, 1'b0, 32'h0000_0300};
    tbl[9]  = '{A_STAT, 32'hC, 1'b1, 32'h0000_0300};
    tbl[10] = '{A_DIV, 32'h0, 1'b1, 32'd2267};
    tbl[11] = '{A_DIV, 32'h0, 1'b0, 32'h0};
    tbl[12] = '{A_CTRL, 32'h1, 1'b1, 32'h0};
    tbl[13] = '{A_CTRL, 32'h0, 1'b0, 32'h1};
    tbl[14] = '{A_STAT, 32'h0, 1'b0, 32'h0000_0200};
    tbl[15] = '{A_STAT, 32'h0, 1'b0, 32'h0000_0100};
    tbl[16] = '{A_STAT, 32'h0, 1'b0, 32'h0000_0001};
    tbl[17] = '{A_STAT, 32'h0, 1'b0, 32'h0000_0009};

    model_reset();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].addr, tbl[i].wdata, tbl[i].we);
      chk($sformatf("tbl_%0d", i), last_rdata, tbl[i].exp_rdata);
    end

    // FIFO order: first popped sample 0x11 gives 17 high clocks per PWM period.
    do_reset();
    cyc(A_DATA, 32'h11, 1'b1);
    cyc(A_DATA, 32'h22, 1'b1);
    cyc(A_DIV, 32'd2, 1'b1);
    cyc(A_CTRL, 32'h1, 1'b1);
    repeat (3) cyc('0, '0, 1'b0);
    cyc(A_DIV, 32'd600, 1'b1);
    cyc('0, '0, 1'b0);
    count_high(255, hi);
    chk("first_pop_duty", 32'(hi), 32'd17);

    // DIV=9: tick exactly 10 clocks after EN, then duty 0x40.
    do_reset();
    cyc(A_DIV, 32'd9, 1'b1);
    cyc(A_DATA, 32'h40, 1'b1);
    cyc(A_CTRL, 32'h1, 1'b1);
    repeat (9) cyc('0, '0, 1'b0);
    cyc(A_STAT, '0, 1'b0);
    chk("pre_tick_stat", last_rdata, 32'h0000_0100);
    cyc(A_STAT, '0, 1'b0);
    chk("post_tick_stat", last_rdata, 32'h0000_0001);
    count_high(255, hi);
    chk("duty_40_high", 32'(hi), 32'd64);

    // Overflow on the 17th push, W1C clear, full FIFO accepting push alongside pop.
    do_reset();
    for (int i = 0; i < 17; i++) cyc(A_DATA, 32'(i + 1), 1'b1);
    cyc(A_STAT, '0, 1'b0);
    chk("ovf_stat", last_rdata, 32'h0000_1006);
    cyc(A_STAT, 32'h4, 1'b1);
    cyc(A_STAT, '0, 1'b0);
    chk("ovf_clear_stat", last_rdata, 32'h0000_1002);
    cyc(A_DIV, 32'd0, 1'b1);
    cyc(A_CTRL, 32'h1, 1'b1);
    cyc(A_DATA, 32'h77, 1'b1);
    cyc(A_STAT, '0, 1'b0);
    chk("full_push_pop_stat", last_rdata, 32'h0000_1002);

    // Underflow on empty FIFO; set event beats a same-cycle W1C.
    do_reset();
    cyc(A_DIV, 32'd3, 1'b1);
    cyc(A_CTRL, 32'h1, 1'b1);
    repeat (4) cyc('0, '0, 1'b0);
    cyc(A_STAT, '0, 1'b0);
    chk("unf_stat", last_rdata, 32'h0000_0009);
    chk("unf_pwm_low", 32'(last_pwm), 32'd0);
    chk("unf_irq", 32'(last_irq), 32'd1);
    repeat (2) cyc('0, '0, 1'b0);
    cyc(A_STAT, 32'h8, 1'b1);
    cyc(A_STAT, '0, 1'b0);
    chk("unf_set_wins", last_rdata, 32'h0000_0009);
    cyc(A_STAT, 32'h8, 1'b1);
    cyc(A_STAT, '0, 1'b0);
    chk("unf_w1c", last_rdata, 32'h0000_0001);

    // Flush followed by a push; flush colliding with a popping tick.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(A_DATA, 32'(8'hA0 + i), 1'b1);
    cyc(A_CTRL, 32'h2, 1'b1);
    cyc(A_DATA, 32'h5A, 1'b1);
    cyc(A_STAT, '0, 1'b0);
    chk("flush_then_push", last_rdata, 32'h0000_0100);
    do_reset();
    cyc(A_DIV, 32'd5, 1'b1);
    for (int i = 0; i < 4; i++) cyc(A_DATA, 32'(8'hC0 + i), 1'b1);
    cyc(A_CTRL, 32'h1, 1'b1);
    repeat (5) cyc('0, '0, 1'b0);
    cyc(A_CTRL, 32'h3, 1'b1);
    cyc(A_STAT, '0, 1'b0);
    chk("flush_on_tick", last_rdata, 32'h0000_0001);
    repeat (20) cyc('0, '0, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    cyc(A_DIV, 32'($urandom_range(0, 7)), 1'b1);
    cyc(A_CTRL, 32'h1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)
        cyc(A_DATA, $urandom, 1'b1);
      else if (r < 50)
        cyc(BASE + 32'($urandom_range(0, 15)), $urandom, 1'b0);
      else if (r < 55)
        cyc(A_STAT, $urandom, 1'b1);
      else if (r < 60) begin
        nd = $urandom & 32'hFFFF_FFFC;
        nd[0] = ($urandom_range(0, 7) != 0);
        nd[1] = ($urandom_range(0, 5) == 0);
        cyc(A_CTRL, nd, 1'b1);
      end else if (r < 63) begin
        nd = 32'($urandom_range(0, 7));
        if (nd <= m_div_cnt) nd = m_div_cnt + 32'd1;
        cyc(A_DIV, nd, 1'b1);
      end else if (r < 66)
        cyc(32'h2000_0000 + 32'($urandom_range(0, 15)), $urandom, 1'b1);
      else
        cyc(32'h0800_0000 + 32'($urandom_range(0, 15)), $urandom, 1'b0);
    end

    // Reset asserted mid-stream.
    do_reset();
    repeat (5) cyc('0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
